// File: rtl/io_in_pkg.sv
// Shared types and width helpers for the INPUT_IO event scanning controller.
package io_in_pkg;

  localparam int unsigned N_IO_DEF       = 8;
  localparam int unsigned DEBOUNCE_DEF   = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  // The event idx field is sized for banks of up to 256 channels; the top trims it.
  localparam int unsigned EVT_IDX_W = 8;

  localparam int unsigned IDX_W_DEF = $clog2(N_IO_DEF);
  localparam int unsigned CNT_W_DEF = $clog2(DEBOUNCE_DEF + 1);
  localparam int unsigned PTR_W_DEF = $clog2(FIFO_DEPTH_DEF);

  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [EVT_IDX_W-1:0] idx;
    logic                 level;
  } io_evt_t;

endpackage

// File: rtl/io_evt_fifo.sv
// Shift-style event FIFO: entry 0 is always the head, so head/valid/full come straight from flops.
module io_evt_fifo
  import io_in_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  io_evt_t din,
  output io_evt_t head,
  output logic    valid,
  output logic    full
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  io_evt_t          mem     [DEPTH];
  io_evt_t          mem_nxt [DEPTH];
  logic             placed;

  // Next-state: pop shifts everything down, then a push lands in the first free slot.
  always_comb begin
    vld_nxt = vld;
    placed  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt[i] = mem[i];
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_nxt[i] = mem[i + 1];
        vld_nxt[i] = vld[i + 1];
      end
      mem_nxt[DEPTH-1] = '0;
      vld_nxt[DEPTH-1] = 1'b0;
    end else begin
      vld_nxt = vld;
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!vld_nxt[i] && !placed) begin
          mem_nxt[i] = din;
          vld_nxt[i] = 1'b1;
          placed     = 1'b1;
        end else begin
          placed = placed;
        end
      end
    end else begin
      placed = 1'b0;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      vld <= vld_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= mem_nxt[i];
      end
    end
  end

  assign head  = mem[0];
  assign valid = vld[0];
  assign full  = vld[DEPTH-1];

endmodule

// File: rtl/io_in_event_ctrl.sv
// Round-robin debounce scanner for a bank of INPUT_IO cells; reports level changes as {idx, level} events.
module io_in_event_ctrl
  import io_in_pkg::*;
#(
  parameter int unsigned N_IO       = 8,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    IQC,
  input  logic                    QRT,
  input  logic [N_IO-1:0]         IQZ_in,
  input  logic                    en,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_IO)-1:0] evt_idx,
  output logic                    evt_level,
  output logic [N_IO-1:0]         stable,
  output logic                    stall_flag,
  input  logic                    stall_clr
);

  localparam int unsigned        IDX_W = $clog2(N_IO);
  localparam int unsigned        CNT_W = width_of(DEBOUNCE + 1);
  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(N_IO - 1);
  localparam logic [CNT_W:0]     DEB   = (CNT_W + 1)'(DEBOUNCE);
  localparam logic [CNT_W-1:0]   SAT   = CNT_W'(DEBOUNCE - 1);

  logic [N_IO-1:0]  sync1;
  logic [N_IO-1:0]  sync2;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt [N_IO];

  logic             cur_in;
  logic             cur_stable;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pop;
  logic             can_push;
  logic             push;
  logic             stall_set;
  logic             fifo_full;
  io_evt_t          push_evt;
  io_evt_t          head;
  logic             unused_idx;

  // Shared datapath: evaluate the channel under the scan pointer.
  always_comb begin
    cur_in     = sync2[ptr];
    cur_stable = stable[ptr];
    cur_cnt    = cnt[ptr];
    pop        = evt_valid & evt_ready;
    can_push   = ~fifo_full | pop;
    cnt_nxt    = cur_cnt;
    push       = 1'b0;
    stall_set  = 1'b0;
    if (en) begin
      if (cur_in == cur_stable) begin
        cnt_nxt = '0;
      end else if (({1'b0, cur_cnt} + (CNT_W + 1)'(1)) < DEB) begin
        cnt_nxt = cur_cnt + CNT_W'(1);
      end else if (can_push) begin
        cnt_nxt = '0;
        push    = 1'b1;
      end else begin
        // Keep the count saturated so the accept is retried on the next visit.
        cnt_nxt   = SAT;
        stall_set = 1'b1;
      end
    end else begin
      cnt_nxt = cur_cnt;
    end
    push_evt.idx   = EVT_IDX_W'(ptr);
    push_evt.level = cur_in;
  end

  // Pad synchronizers.
  always_ff @(posedge IQC) begin
    if (QRT) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= IQZ_in;
      sync2 <= sync1;
    end
  end

  // Scan pointer, per-channel counters and debounced levels.
  always_ff @(posedge IQC) begin
    if (QRT) begin
      ptr    <= '0;
      stable <= '0;
      for (int i = 0; i < N_IO; i++) begin
        cnt[i] <= '0;
      end
    end else if (en) begin
      cnt[ptr] <= cnt_nxt;
      ptr      <= (ptr == LAST) ? '0 : ptr + IDX_W'(1);
      if (push) begin
        stable[ptr] <= cur_in;
      end
    end
  end

  // Sticky stall flag; a new stall beats a clear in the same cycle.
  always_ff @(posedge IQC) begin
    if (QRT) begin
      stall_flag <= 1'b0;
    end else if (stall_set) begin
      stall_flag <= 1'b1;
    end else if (stall_clr) begin
      stall_flag <= 1'b0;
    end
  end

  io_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (IQC),
    .rst   (QRT),
    .push  (push),
    .pop   (pop),
    .din   (push_evt),
    .head  (head),
    .valid (evt_valid),
    .full  (fifo_full)
  );

  assign evt_idx    = head.idx[IDX_W-1:0];
  assign evt_level  = head.level;
  assign unused_idx = ^head.idx;

endmodule

// File: tb/tb_io_in_event_ctrl.sv
// Directed scenarios plus a randomized phase, checked every cycle against a queue-based reference model.
module tb_io_in_event_ctrl;

  localparam int N     = 4;
  localparam int DEB   = 3;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       qrt;
  logic       en;
  logic       evt_ready;
  logic       stall_clr;
  logic [3:0] iqz;
  logic       evt_valid;
  logic       evt_level;
  logic       stall_flag;
  logic [1:0] evt_idx;
  logic [3:0] stable;

  always #5 clk = ~clk;

  io_in_event_ctrl #(
    .N_IO       (N),
    .DEBOUNCE   (DEB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .IQC        (clk),
    .QRT        (qrt),
    .IQZ_in     (iqz),
    .en         (en),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_idx    (evt_idx),
    .evt_level  (evt_level),
    .stable     (stable),
    .stall_flag (stall_flag),
    .stall_clr  (stall_clr)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: pad history queue, scan counter, per-channel run lengths, event queue.
  logic [3:0] m_hist[$];
  int         m_ptr;
  int         m_cnt[N];
  logic [3:0] m_stable;
  int         m_fifo[$];
  bit         m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist = {4'b0000, 4'b0000};
    m_ptr  = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_stable = 4'b0000;
    m_fifo.delete();
    m_stall = 1'b0;
  endtask

  task automatic check_all();
    chk("evt_valid", 32'(evt_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      chk("evt_idx", 32'(evt_idx), 32'(m_fifo[0] / 2));
      chk("evt_level", 32'(evt_level), 32'(m_fifo[0] % 2));
    end
    chk("stable", 32'(stable), 32'(m_stable));
    chk("stall_flag", 32'(stall_flag), 32'(m_stall));
    chk("ptr", 32'(dut.ptr), 32'(m_ptr));
  endtask

  // One clock: advance the model with the inputs present before the edge, then compare.
  task automatic step();
    logic [3:0] s;
    bit         pop;
    bit         pushed;
    bit         set_stall;
    int         c;
    int         ev;
    if (qrt) begin
      model_reset();
    end else begin
      s = m_hist[0];
      void'(m_hist.pop_front());
      m_hist.push_back(iqz);
      pop       = (m_fifo.size() > 0) && evt_ready;
      pushed    = 1'b0;
      set_stall = 1'b0;
      ev        = 0;
      if (en) begin
        c = m_ptr;
        if (s[c] == m_stable[c]) begin
          m_cnt[c] = 0;
        end else if (m_cnt[c] + 1 < DEB) begin
          m_cnt[c] = m_cnt[c] + 1;
        end else if (m_fifo.size() < DEPTH || pop) begin
          ev          = c * 2 + int'(s[c]);
          pushed      = 1'b1;
          m_stable[c] = s[c];
          m_cnt[c]    = 0;
        end else begin
          m_cnt[c]  = DEB - 1;
          set_stall = 1'b1;
        end
        m_ptr = (m_ptr + 1) % N;
      end
      if (pop) void'(m_fifo.pop_front());
      if (pushed) m_fifo.push_back(ev);
      if (set_stall) m_stall = 1'b1;
      else if (stall_clr) m_stall = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  initial begin
    int start;
    int nev;
    int idx_seen;
    int lvl_seen;
    int p;
    int got[$];
    bit done;

    qrt       = 1'b1;
    en        = 1'b1;
    evt_ready = 1'b0;
    stall_clr = 1'b0;
    iqz       = 4'b0000;
    model_reset();

    // Reset, then idle: pointer walks 0,1,2,3,0.
    step();
    step();
    qrt = 1'b0;
    chk("t1_ptr_reset", 32'(dut.ptr), 32'd0);
    chk("t1_valid_reset", 32'(evt_valid), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t1_ptr_seq", 32'(dut.ptr), 32'(i % 4));
    end

    // Single clean rising edge on channel 2.
    evt_ready = 1'b1;
    iqz[2]    = 1'b1;
    start     = cyc;
    nev       = 0;
    idx_seen  = -1;
    lvl_seen  = -1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (evt_valid) begin
        if (nev == 0) begin
          chk("t2_latency_min", 32'(cyc - start >= 11), 32'd1);
          chk("t2_latency_max", 32'(cyc - start <= 14), 32'd1);
        end
        nev++;
        idx_seen = int'(evt_idx);
        lvl_seen = int'(evt_level);
      end
    end
    chk("t2_event_count", 32'(nev), 32'd1);
    chk("t2_idx", 32'(idx_seen), 32'd2);
    chk("t2_level", 32'(lvl_seen), 32'd1);
    chk("t2_stable", 32'(stable), 32'b0100);

    // Short glitch on channel 1 never reaches the debounce threshold.
    iqz[1] = 1'b1;
    repeat (6) step();
    iqz[1] = 1'b0;
    repeat (12) step();
    chk("t3_cnt1", 32'(dut.cnt[1]), 32'd0);
    chk("t3_stable1", 32'(stable[1]), 32'd0);

    // Back-pressure: channels 0,1 queue, channel 3 stalls until the consumer drains.
    evt_ready = 1'b0;
    done      = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      if (m_ptr == 2) done = 1'b1;
      else step();
    end
    chk("t4_align", 32'(done), 32'd1);
    iqz = iqz | 4'b1011;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (m_stall) done = 1'b1;
    end
    chk("t4_stall_seen", 32'(stall_flag), 32'd1);
    chk("t4_head_idx", 32'(evt_idx), 32'd0);
    evt_ready = 1'b1;
    for (int i = 0; i < 24 && got.size() < 3; i++) begin
      if (evt_valid) got.push_back(int'(evt_idx));
      step();
    end
    chk("t4_event_count", 32'(got.size()), 32'd3);
    if (got.size() > 0) chk("t4_order0", 32'(got[0]), 32'd0);
    if (got.size() > 1) chk("t4_order1", 32'(got[1]), 32'd1);
    if (got.size() > 2) chk("t4_order2", 32'(got[2]), 32'd3);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("t4_stall_clr", 32'(stall_flag), 32'd0);

    // Freeze the scan mid-count on channel 0, then resume.
    iqz[0] = 1'b0;
    done   = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      step();
      if (m_cnt[0] == 1) done = 1'b1;
    end
    chk("t5_cnt_reached", 32'(dut.cnt[0]), 32'd1);
    en = 1'b0;
    p  = int'(dut.ptr);
    repeat (8) step();
    chk("t5_ptr_frozen", 32'(dut.ptr), 32'(p));
    chk("t5_cnt_held", 32'(dut.cnt[0]), 32'd1);
    chk("t5_no_event", 32'(evt_valid), 32'd0);
    en   = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      step();
      if (evt_valid) done = 1'b1;
    end
    chk("t5_resume_event", 32'(evt_valid), 32'd1);
    chk("t5_resume_idx", 32'(evt_idx), 32'd0);
    chk("t5_resume_level", 32'(evt_level), 32'd0);

    // Reset with a full FIFO and a pending stall.
    evt_ready = 1'b0;
    iqz       = iqz & 4'b0001;
    done      = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (m_fifo.size() == 2 && m_stall) done = 1'b1;
    end
    chk("t6_full_valid", 32'(evt_valid), 32'd1);
    chk("t6_full_stall", 32'(stall_flag), 32'd1);
    qrt = 1'b1;
    step();
    qrt = 1'b0;
    chk("t6_valid", 32'(evt_valid), 32'd0);
    chk("t6_stable", 32'(stable), 32'd0);
    chk("t6_stall", 32'(stall_flag), 32'd0);
    chk("t6_idx", 32'(evt_idx), 32'd0);
    chk("t6_level", 32'(evt_level), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 15) == 0) iqz[b] = ~iqz[b];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      stall_clr = ($urandom_range(0, 7) == 0);
      qrt       = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
